// File: rtl/sort_frame_ctrl.sv
// sort_frame_ctrl
//   Sequencer around a 4-input, 8-bit combinational sorter. It collects four
//   serial words into a frame, presents the frame to the sorter, and after
//   SORT_WAIT cycles captures the sorted result. It then replays the result
//   serially, smallest first, and flags the fourth word with out_last.
//
// Parameters
//   SORT_WAIT  cycles spent in SORT before sampling the sorter (1..15)
//   CNT_W      width of the completed-frame counter
//
// Ports
//   clk, rst_n                 clock, synchronous active-low reset
//   in_valid/in_ready/in_data  serial input words (valid/ready)
//   sort_in1..4                frame words 0..3 driven to the sorter
//   sort_out1..4               sorted words from the sorter, ascending
//   out_valid/out_ready        serial output words (valid/ready)
//   out_data/out_last          output word, last-word-of-frame marker
//   busy                       high while sorting or draining
//   frame_cnt                  number of fully drained frames (wraps)
module sort_frame_ctrl #(
  parameter int SORT_WAIT = 1,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  output logic [7:0]       sort_in1,
  output logic [7:0]       sort_in2,
  output logic [7:0]       sort_in3,
  output logic [7:0]       sort_in4,
  input  logic [7:0]       sort_out1,
  input  logic [7:0]       sort_out2,
  input  logic [7:0]       sort_out3,
  input  logic [7:0]       sort_out4,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic             out_last,
  output logic             busy,
  output logic [CNT_W-1:0] frame_cnt
);

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    SORT  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Counter reload value: SORT_WAIT-1 makes SORT last exactly SORT_WAIT cycles.
  localparam logic [3:0] WAIT_INIT = 4'(SORT_WAIT - 1);

  state_t           state_q, state_d;
  logic [1:0]       load_idx_q, load_idx_d;
  logic [3:0]       wait_q, wait_d;
  logic [1:0]       drain_idx_q, drain_idx_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [7:0]       sin_q [4];
  logic [7:0]       sin_d [4];
  logic [7:0]       res_q [4];
  logic [7:0]       res_d [4];

  always_comb begin
    state_d     = state_q;
    load_idx_d  = load_idx_q;
    wait_d      = wait_q;
    drain_idx_d = drain_idx_q;
    frame_cnt_d = frame_cnt_q;
    for (int i = 0; i < 4; i++) begin
      sin_d[i] = sin_q[i];
      res_d[i] = res_q[i];
    end
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_data  = 8'd0;
    out_last  = 1'b0;
    busy      = 1'b0;

    case (state_q)
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          sin_d[load_idx_q] = in_data;
          if (load_idx_q == 2'd3) begin
            state_d    = SORT;
            load_idx_d = 2'd0;
            wait_d     = WAIT_INIT;
          end else begin
            load_idx_d = load_idx_q + 2'd1;
          end
        end
      end

      SORT: begin
        busy = 1'b1;
        // The sorter has had SORT_WAIT cycles to settle on the held frame.
        if (wait_q == 4'd0) begin
          res_d[0] = sort_out1;
          res_d[1] = sort_out2;
          res_d[2] = sort_out3;
          res_d[3] = sort_out4;
          state_d  = DRAIN;
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end

      DRAIN: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_data  = res_q[drain_idx_q];
        out_last  = (drain_idx_q == 2'd3);
        if (out_ready) begin
          if (drain_idx_q == 2'd3) begin
            state_d     = LOAD;
            drain_idx_d = 2'd0;
            frame_cnt_d = frame_cnt_q + CNT_W'(1);
          end else begin
            drain_idx_d = drain_idx_q + 2'd1;
          end
        end
      end

      default: begin
        state_d = LOAD;
      end
    endcase
  end

  // Control state and the sorter input registers are cleared by reset so a
  // partial frame never leaks into the next one.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= LOAD;
      load_idx_q  <= 2'd0;
      wait_q      <= 4'd0;
      drain_idx_q <= 2'd0;
      frame_cnt_q <= '0;
      for (int i = 0; i < 4; i++) sin_q[i] <= 8'd0;
    end else begin
      state_q     <= state_d;
      load_idx_q  <= load_idx_d;
      wait_q      <= wait_d;
      drain_idx_q <= drain_idx_d;
      frame_cnt_q <= frame_cnt_d;
      for (int i = 0; i < 4; i++) sin_q[i] <= sin_d[i];
    end
  end

  // Result words are only observable in DRAIN, which is always entered
  // through a capture, so they need no reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) res_q[i] <= res_d[i];
  end

  assign sort_in1  = sin_q[0];
  assign sort_in2  = sin_q[1];
  assign sort_in3  = sin_q[2];
  assign sort_in4  = sin_q[3];
  assign frame_cnt = frame_cnt_q;

endmodule

// File: doc/sort_frame_ctrl.md
Name: sort_frame_ctrl

Overview:
- Sequencer for the 4-input, 8-bit combinational `sort` block.
- Accepts a serial stream of 8-bit words on a valid/ready input and groups them into 4-word frames.
- Presents each frame in parallel to `sort`, captures the sorted result, then replays it serially on a valid/ready output with a last-word marker.
- `sort` is instantiated beside this block in the parent; this block only drives its inputs and samples its outputs.

Parameters:
- SORT_WAIT, 1, cycles spent in SORT state before capturing `sort` outputs (legal range 1..15; covers sorter settling or later pipelining of `sort`).
- CNT_W, 16, width of the completed-frame counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  input word valid.
- in_ready  output  1  block can accept an input word.
- in_data  input  8  input word.
- sort_in1..sort_in4  output  8 each  frame words 0..3, to `sort` in1..in4.
- sort_out1..sort_out4  input  8 each  from `sort` out1..out4 (out1 = smallest, ascending).
- out_valid  output  1  output word valid.
- out_ready  input  1  downstream accepts the output word.
- out_data  output  8  output word.
- out_last  output  1  high with the 4th word of a frame.
- busy  output  1  high in SORT or DRAIN.
- frame_cnt  output  CNT_W  count of completely drained frames.

Behaviour:
- States: LOAD, SORT, DRAIN. Reset state is LOAD.
- Reset values (applied at the clk edge while rst_n=0): all outputs 0 except in_ready=1. This includes sort_in1..4, out_data, frame_cnt, load index, wait counter and drain index.
- LOAD:
  - in_ready=1, out_valid=0.
  - An accept is in_valid & in_ready at the clk edge. Each accept writes in_data to sort_in[load_idx] and increments load_idx (0..3).
  - The accept at load_idx=3 moves the block to SORT, resets load_idx to 0 and loads the wait counter with SORT_WAIT-1.
  - in_valid=0 holds state. Gaps between words are allowed.
- SORT:
  - in_ready=0, busy=1.
  - sort_in1..4 are held stable.
  - The wait counter decrements each cycle. In the cycle it reads 0, sort_out1..4 are registered into result[0..3] and the state moves to DRAIN.
  - SORT_WAIT=1 therefore means exactly one SORT cycle.
- DRAIN:
  - out_valid=1 and out_data=result[drain_idx].
  - out_last=1 when drain_idx=3.
  - out_ready=0 holds out_data, out_last and drain_idx stable; out_valid stays high.
  - Each out_valid & out_ready advances drain_idx.
  - The handshake with out_last=1 returns the state to LOAD, resets drain_idx and increments frame_cnt.
- frame_cnt wraps from all-ones to 0 without saturation.
- Latency: from the edge accepting word 3 to the first out_valid=1 is SORT_WAIT+1 cycles.
- Minimum frame period with continuous valid/ready is 4 + SORT_WAIT + 4 cycles.
- There is no input/output overlap: in_ready=0 throughout SORT and DRAIN.
- sort_in registers keep the last frame until they are overwritten during the next LOAD.
- Reset mid-frame (any state): any partial input frame or undrained result is discarded, with no output pulse, and the block returns to LOAD. frame_cnt is cleared.
- in_data is ignored whenever in_ready=0. out_ready is ignored whenever out_valid=0.

Test Plan:
- Reset then single frame: send 13,1,23,10 back-to-back with out_ready=1.
  - sort_in1..4 = 13,1,23,10.
  - out_data = 1,10,13,23 on 4 consecutive cycles, out_last only on 23.
  - First out_valid 2 cycles after the 4th accept (SORT_WAIT=1). frame_cnt=1.
- Output backpressure: same frame, out_ready toggled 0,0,1,0,1,1,0,1.
  - Each word is held stable while out_ready=0.
  - Exactly 4 handshakes occur, in order 1,10,13,23.
  - in_ready=0 until the last one.
- Input gaps and duplicates: send 200,200,0,255 with in_valid low 1-3 cycles between words.
  - Output is 0,200,200,255.
  - No word is accepted while in_valid=0.
- SORT_WAIT=4 build: send 7,6,5,4.
  - busy=1 and in_ready=0 for 4 SORT cycles.
  - First out_valid 5 cycles after the 4th accept. Output 4,5,6,7.
- Reset mid-operation:
  - Case A: rst_n=0 for 1 cycle after 2 words. Next frame 9,3,8,2 outputs 2,3,8,9 with no stale words.
  - Case B: reset during DRAIN after 2 words out. out_valid=0 and frame_cnt=0 next cycle.
- Counter wrap (CNT_W=2 build): drain 5 frames -> frame_cnt sequence 1,2,3,0,1.
